// File: rtl/bram_dp_wm.sv
// bram_dp_wm: parameterised true dual-port synchronous RAM with per-bit
// write masks, selectable read-during-write behaviour, an optional output
// register, port-0-wins collision arbitration and a hardware clear engine.
module bram_dp_wm #(
    parameter int               WIDTH      = 16,
    parameter int               DEPTH      = 1024,
    parameter int               ADDR_W     = 10,
    parameter int               WRITE_MODE = 0,
    parameter int               OUT_REG    = 0,
    parameter logic [WIDTH-1:0] CLEAR_VAL  = '0
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic [ADDR_W-1:0] A0,
    input  logic [WIDTH-1:0]  D0,
    output logic [WIDTH-1:0]  Q0,
    input  logic              WE0,
    input  logic [WIDTH-1:0]  WEM0,
    input  logic              CE0,
    input  logic [ADDR_W-1:0] A1,
    input  logic [WIDTH-1:0]  D1,
    output logic [WIDTH-1:0]  Q1,
    input  logic              WE1,
    input  logic [WIDTH-1:0]  WEM1,
    input  logic              CE1,
    input  logic              CLR,
    output logic              READY,
    output logic              COLL
);

    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic              ready;

    logic [WIDTH-1:0]  mem [DEPTH];

    logic              en0, en1, in0, in1, wr0, wr1, same, coll_nxt;
    logic [WIDTH-1:0]  old0, old1, new0, new1, rd0, rd1;
    logic [WIDTH-1:0]  q0_p1, q1_p1;
    logic              coll_p1;

    // Replace only the bits selected by mask.
    function automatic logic [WIDTH-1:0] merge_bits(input logic [WIDTH-1:0] base,
                                                    input logic [WIDTH-1:0] data,
                                                    input logic [WIDTH-1:0] mask);
        return (base & ~mask) | (data & mask);
    endfunction

    // Same-address double write: port 0 owns every bit it masks.
    function automatic logic [WIDTH-1:0] resolve(input logic [WIDTH-1:0] base,
                                                 input logic [WIDTH-1:0] d_a,
                                                 input logic [WIDTH-1:0] m_a,
                                                 input logic [WIDTH-1:0] d_b,
                                                 input logic [WIDTH-1:0] m_b);
        return (base & ~(m_a | m_b)) | (d_a & m_a) | (d_b & m_b & ~m_a);
    endfunction

    // Clear engine / run-state sequencer; READY is a registered FSM output.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= S_CLEAR;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                S_CLEAR: begin
                    if (cnt == LAST) begin
                        state <= S_RUN;
                        ready <= 1'b1;
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end
                S_RUN: begin
                    if (CLR) begin
                        state <= S_CLEAR;
                        cnt   <= '0;
                        ready <= 1'b0;
                    end
                end
                default: begin
                    state <= S_CLEAR;
                    cnt   <= '0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // Access decode: gating, range check, merged write words and read muxes.
    always_comb begin
        en0  = CE0 & ready;
        en1  = CE1 & ready;
        in0  = {1'b0, A0} < DEPTH_C;
        in1  = {1'b0, A1} < DEPTH_C;
        old0 = in0 ? mem[A0] : '0;
        old1 = in1 ? mem[A1] : '0;
        wr0  = en0 & WE0 & in0;
        wr1  = en1 & WE1 & in1;
        same = in0 & in1 & (A0 == A1);
        new0 = merge_bits(old0, D0, WEM0);
        new1 = merge_bits(old1, D1, WEM1);
        if (same && wr0 && wr1) begin
            new0 = resolve(old0, D0, WEM0, D1, WEM1);
            new1 = new0;
        end
        rd0 = '0;
        rd1 = '0;
        if (in0) rd0 = (WRITE_MODE != 0 && wr0) ? new0 : old0;
        if (in1) rd1 = (WRITE_MODE != 0 && wr1) ? new1 : old1;
        coll_nxt = en0 & en1 & same & (WE0 | WE1);
    end

    // Storage array: clear fill while clearing, user writes while running.
    always_ff @(posedge CLK) begin
        if (state == S_CLEAR) begin
            if (RSTN) mem[cnt] <= CLEAR_VAL;
        end else begin
            if (wr1) mem[A1] <= new1;
            if (wr0) mem[A0] <= new0;
        end
    end

    // ---- stage 1: read data and collision flag ----
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            q0_p1   <= '0;
            q1_p1   <= '0;
            coll_p1 <= 1'b0;
        end else begin
            if (en0) q0_p1 <= rd0;
            if (en1) q1_p1 <= rd1;
            coll_p1 <= coll_nxt;
        end
    end

    assign READY = ready;
    assign COLL  = coll_p1;

    // ---- stage 2: optional output register ----
    if (OUT_REG != 0) begin : g_oreg
        logic [WIDTH-1:0] q0_p2, q1_p2;

        // Output register follows stage 1 unconditionally.
        always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
                q0_p2 <= '0;
                q1_p2 <= '0;
            end else begin
                q0_p2 <= q0_p1;
                q1_p2 <= q1_p1;
            end
        end

        assign Q0 = q0_p2;
        assign Q1 = q1_p2;
    end else begin : g_noreg
        assign Q0 = q0_p1;
        assign Q1 = q1_p1;
    end

endmodule

// File: doc/bram_dp_wm.md
Name: bram_dp_wm

Overview:
- Parametrised true dual-port synchronous RAM; successor to the fixed 1024x16 BRAM wrappers in tech/virtex7.
- Adds the following over the fixed wrappers:
  - configurable width and depth;
  - functional per-bit write mask (WEM);
  - selectable read-during-write mode;
  - optional output pipeline register;
  - defined port-collision arbitration with a collision flag;
  - hardware clear engine that fills memory after reset or on request.
- Sits between accelerator datapaths and the memory subsystem as a drop-in bank.

Parameters:
- WIDTH, 16, data/mask width in bits.
- DEPTH, 1024, number of words; must satisfy DEPTH <= 2**ADDR_W.
- ADDR_W, 10, address width.
- WRITE_MODE, 0, 0 = READ_FIRST (Q returns old word on write); 1 = WRITE_FIRST (Q returns merged new word).
- OUT_REG, 0, 0 = read latency 1; 1 = read latency 2 via extra output register.
- CLEAR_VAL, 0, WIDTH-bit fill value written by the clear engine.

Ports:
- CLK  in  1  clock; all state on rising edge.
- RSTN  in  1  reset, asynchronous, active-low.
- A0  in  ADDR_W  port 0 address.
- D0  in  WIDTH  port 0 write data.
- Q0  out  WIDTH  port 0 read data.
- WE0  in  1  port 0 write enable.
- WEM0  in  WIDTH  port 0 bit write mask, 1 = bit written.
- CE0  in  1  port 0 enable.
- A1, D1, Q1, WE1, WEM1, CE1  as port 0, for port 1.
- CLR  in  1  single-cycle request to refill memory with CLEAR_VAL.
- READY  out  1  high when the memory accepts accesses.
- COLL  out  1  one-cycle pulse flagging a same-address write collision.

Behaviour:
- Reset (RSTN low, async):
  - Q0, Q1, COLL, READY = 0; pipeline registers = 0.
  - FSM = CLEAR, clear counter = 0.
  - Memory contents are not reset directly.
- FSM states:
  - CLEAR: each cycle writes CLEAR_VAL to mem[cnt] and increments cnt. When cnt == DEPTH-1 the FSM writes that word and moves to RUN. READY rises the first cycle in RUN, i.e. DEPTH cycles after the first clock edge with RSTN high.
  - RUN: READY = 1; user accesses enabled.
  - CLR = 1 in RUN: next cycle FSM = CLEAR, cnt = 0, READY = 0.
  - CLR in CLEAR is ignored.
- While READY = 0:
  - CE0/CE1 are internally gated off; writes are dropped.
  - Q0/Q1 hold their value; COLL = 0.
- Write (CEx & WEx & READY, A < DEPTH): mem[A] <= (mem[A] & ~WEMx) | (Dx & WEMx).
  - WEMx = 0 writes nothing but still performs the read.
- Read (CEx & READY):
  - Stage-1 register loads mem[A] (WRITE_MODE 0) or the merged word (WRITE_MODE 1).
  - Q = stage-1 when OUT_REG = 0.
  - With OUT_REG = 1, the output register copies stage-1 every cycle.
  - CEx low: stage-1 holds, so Q holds.
- Out-of-range address (A >= DEPTH): write ignored; read returns 0.
- Collision (CE0 & CE1 & READY, A0 == A1 < DEPTH, WE0 | WE1):
  - Bits masked by both ports take D0 (port 0 wins).
  - Bits masked by one port take that port's data.
  - Reading-only port returns the pre-write word regardless of WRITE_MODE.
  - Writing port follows its WRITE_MODE, merged with the winning result.
  - COLL = 1 for exactly one cycle, aligned with stage-1 (latency 1, independent of OUT_REG).
- Both ports reading the same address without writes: no collision; both return the word.
- Reset asserted mid-clear or mid-access: immediate return to reset values; the full clear restarts on release.

Test Plan:
1. Reset, release RSTN, default params -> READY = 0 for 1024 cycles, 1 on cycle 1024; read A0 = 5 returns 0x0000 one cycle later.
2. Write 0xFFFF to addr 3, then D0 = 0x1234, WEM0 = 0x00FF to addr 3, then read -> Q0 = 0xFF34.
3. mem[9] = 0x5555; write 0xAAAA, full mask, to addr 9 -> Q0 = 0x5555 with WRITE_MODE = 0; Q0 = 0xAAAA with WRITE_MODE = 1; subsequent read = 0xAAAA in both.
4. Same-cycle writes to addr 7, D0 = 0x1111/WEM0 = 0xFF00 and D1 = 0x2222/WEM1 = 0xFFFF -> mem[7] = 0x1122; COLL high exactly one cycle.
5. OUT_REG = 1: read addr 3 -> Q0 valid 2 cycles later; drop CE0 afterwards -> Q0 holds 0xFF34.
6. Pulse RSTN low at clear cycle 500 -> READY stays 0, Q = 0, clear restarts with 1024 more cycles. CLR in RUN -> READY drops next cycle, previously written addr 3 then reads CLEAR_VAL.
